lut_stream_rx: RTL and testbench

- AXI-Stream-style slave that receives the lookup-table stream produced by sim_lut (ltvalid/ltdata/ltlast/ltready) and captures one frame into an internal RAM.
- Provides a synchronous read port, frame-length reporting and length/overflow error flags.
- Re-arms for the next frame on a `clear` pulse.
- Used as the consumer end of the LUT fetch path and as the self-checking sink in Fetch simulations.

---
 rtl/lut_stream_if.sv | 24 ++
 rtl/lut_stream_rx.sv | 154 +++++++++++++++
 tb/tb_lut_stream_rx.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lut_stream_if.sv
// Valid/ready stream carrying lookup-table words from a producer (sim_lut)
// to a sink; the master drives data, the slave drives ready.
interface lut_stream_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  ltvalid;
    logic [DATA_WIDTH-1:0] ltdata;
    logic                  ltlast;
    logic                  ltready;

    modport master (
        output ltvalid,
        output ltdata,
        output ltlast,
        input  ltready
    );

    modport slave (
        input  ltvalid,
        input  ltdata,
        input  ltlast,
        output ltready
    );
endinterface

// File: rtl/lut_stream_rx.sv
// Stream sink that captures one LUT frame into a local RAM, reports its length
// and length/overflow errors, and serves a registered read port.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_RECV | ltready high, beats written to RAM until an accepted ltlast
// S_DONE | frame captured, ltready low, status frozen until clear
module lut_stream_rx #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int EXP_LEN    = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    lut_stream_if.slave           s_lt,
    input  logic                  clear,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  frame_done,
    output logic [ADDR_WIDTH:0]   frame_len,
    output logic                  len_err,
    output logic                  overflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] C_EXP = (ADDR_WIDTH+1)'(EXP_LEN);
    localparam logic [ADDR_WIDTH:0] C_ONE = (ADDR_WIDTH+1)'(1);

    typedef enum logic {
        S_RECV = 1'b0,
        S_DONE = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic [ADDR_WIDTH:0]   r_count;
    logic [ADDR_WIDTH:0]   r_frame_len;
    logic                  r_ready;
    logic                  r_frame_done;
    logic                  r_len_err;
    logic                  r_overflow;

    logic                  w_accept;
    logic                  w_keep;
    logic                  w_room;
    logic                  w_store;
    logic                  w_drop;
    logic                  w_finish;
    logic [ADDR_WIDTH:0]   w_count_inc;
    logic                  w_ready_nxt;

    // Handshake only uses registered ready, so ready never follows ltvalid.
    assign w_accept    = s_lt.ltvalid & r_ready;
    // A beat that coincides with clear completes the handshake but is discarded.
    assign w_keep      = w_accept & ~clear;
    // The count's MSB is set exactly when the RAM is full (count == DEPTH).
    assign w_room      = ~r_count[ADDR_WIDTH];
    assign w_store     = w_keep & w_room;
    assign w_drop      = w_keep & ~w_room;
    assign w_finish    = w_keep & s_lt.ltlast;
    assign w_count_inc = w_room ? (r_count + C_ONE) : r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_RECV;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RECV: begin
                if (w_finish) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (clear) begin
                    w_state_nxt = S_RECV;
                end
            end
            default: w_state_nxt = S_RECV;
        endcase
    end

    always_comb begin
        w_ready_nxt = 1'b0;
        if (w_state_nxt == S_RECV) begin
            w_ready_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ready      <= 1'b0;
            r_count      <= '0;
            r_frame_len  <= '0;
            r_frame_done <= 1'b0;
            r_len_err    <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_ready <= w_ready_nxt;
            if (clear) begin
                r_count      <= '0;
                r_frame_len  <= '0;
                r_frame_done <= 1'b0;
                r_len_err    <= 1'b0;
                r_overflow   <= 1'b0;
            end else begin
                if (w_store) begin
                    r_count <= w_count_inc;
                end
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
                // Length check includes an overflow raised by the closing beat itself.
                if (w_finish) begin
                    r_frame_done <= 1'b1;
                    r_frame_len  <= w_count_inc;
                    r_len_err    <= (w_count_inc != C_EXP) | r_overflow | w_drop;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    // RAM has no reset; write address is the running beat count.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_count[ADDR_WIDTH-1:0]] <= s_lt.ltdata;
        end
    end

    assign s_lt.ltready = r_ready;
    assign rd_data      = r_rd_data;
    assign frame_done   = r_frame_done;
    assign frame_len    = r_frame_len;
    assign len_err      = r_len_err;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_lut_stream_rx.sv
// Directed bench for lut_stream_rx: frames of various lengths, gapped source,
// overflow, clear and reset mid-frame, with readback of captured words.
module tb_lut_stream_rx;

    logic        clk;
    logic        rst;
    logic        clear;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
    logic        frame_done;
    logic [8:0]  frame_len;
    logic        len_err;
    logic        overflow;

    int total;
    int bad;

    lut_stream_if #(.DATA_WIDTH(32)) u_if ();

    lut_stream_rx #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (8),
        .EXP_LEN    (256)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .s_lt       (u_if),
        .clear      (clear),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .frame_done (frame_done),
        .frame_len  (frame_len),
        .len_err    (len_err),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; returns just after the falling edge
    // that follows the accepting rising edge.
    task automatic send_beat(input logic [31:0] d, input logic last,
                             output int waits, output bit ok);
        waits = 0;
        u_if.ltvalid = 1'b1;
        u_if.ltdata  = d;
        u_if.ltlast  = last;
        while (!u_if.ltready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        ok = u_if.ltready;
        @(negedge clk);
        u_if.ltvalid = 1'b0;
        u_if.ltlast  = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi, input int base,
                              input int last_at, input bit gapped,
                              output int stalls, output int fails);
        int w;
        bit ok;
        stalls = 0;
        fails  = 0;
        for (int i = lo; i < hi; i++) begin
            send_beat(32'(base + i), (i == last_at), w, ok);
            stalls += w;
            if (!ok) fails++;
            if (gapped && (i % 3 == 2)) @(negedge clk);
        end
    endtask

    task automatic rd(input int a, output logic [31:0] d);
        rd_en   = 1'b1;
        rd_addr = 8'(a);
        @(negedge clk);
        rd_en   = 1'b0;
        d       = rd_data;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        int          st;
        int          fl;
        int          errs;
        logic [31:0] d;

        total = 0;
        bad   = 0;
        rst   = 1'b0;
        clear = 1'b0;
        rd_en = 1'b0;
        rd_addr = '0;
        u_if.ltvalid = 1'b0;
        u_if.ltdata  = '0;
        u_if.ltlast  = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(u_if.ltready), 0);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_len", 32'(frame_len), 0);
        chk("rst_lenerr", 32'(len_err), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_rddata", rd_data, 0);

        rst = 1'b1;
        chk("ready_before_edge", 32'(u_if.ltready), 0);
        @(negedge clk);
        chk("ready_after_release", 32'(u_if.ltready), 1);

        // Continuous 256-beat frame, data = index
        send_range(0, 255, 0, 255, 1'b0, st, fl);
        chk("f1_done_early", 32'(frame_done), 0);
        send_range(255, 256, 0, 255, 1'b0, st, fl);
        chk("f1_done", 32'(frame_done), 1);
        chk("f1_len", 32'(frame_len), 256);
        chk("f1_lenerr", 32'(len_err), 0);
        chk("f1_ovf", 32'(overflow), 0);
        chk("f1_ready_done", 32'(u_if.ltready), 0);
        rd(0, d);   chk("f1_rd0", d, 0);
        rd(17, d);  chk("f1_rd17", d, 17);
        rd(255, d); chk("f1_rd255", d, 255);

        // Gapped 3-on/1-off frame with full readback
        pulse_clear();
        chk("clr_done", 32'(frame_done), 0);
        chk("clr_len", 32'(frame_len), 0);
        chk("clr_ready", 32'(u_if.ltready), 1);
        send_range(0, 256, 32'h100, 255, 1'b1, st, fl);
        chk("f2_stalls", 32'(st), 0);
        chk("f2_fails", 32'(fl), 0);
        chk("f2_done", 32'(frame_done), 1);
        chk("f2_len", 32'(frame_len), 256);
        chk("f2_lenerr", 32'(len_err), 0);
        errs = 0;
        for (int a = 0; a < 256; a++) begin
            rd(a, d);
            if (d !== 32'(32'h100 + a)) errs++;
        end
        chk("f2_readback_errs", 32'(errs), 0);

        // Short 10-beat frame, then beats held while DONE must stall
        pulse_clear();
        send_range(0, 10, 32'h200, 9, 1'b0, st, fl);
        chk("f3_len", 32'(frame_len), 10);
        chk("f3_lenerr", 32'(len_err), 1);
        chk("f3_ovf", 32'(overflow), 0);
        chk("f3_ready", 32'(u_if.ltready), 0);
        u_if.ltvalid = 1'b1;
        u_if.ltdata  = 32'hdead;
        repeat (5) @(negedge clk);
        chk("f3_stall_ready", 32'(u_if.ltready), 0);
        chk("f3_stall_len", 32'(frame_len), 10);
        u_if.ltvalid = 1'b0;
        rd(9, d);  chk("f3_rd9", d, 32'h209);
        rd(10, d); chk("f3_rd10_untouched", d, 32'h10a);

        // 260-beat frame: overflow on beat 257
        pulse_clear();
        send_range(0, 256, 500, 259, 1'b0, st, fl);
        chk("f4_ovf_at_256", 32'(overflow), 0);
        chk("f4_ready_at_256", 32'(u_if.ltready), 1);
        send_range(256, 260, 500, 259, 1'b0, st, fl);
        chk("f4_fails", 32'(fl), 0);
        chk("f4_ovf", 32'(overflow), 1);
        chk("f4_lenerr", 32'(len_err), 1);
        chk("f4_len", 32'(frame_len), 256);
        chk("f4_done", 32'(frame_done), 1);
        rd(0, d);   chk("f4_rd0", d, 500);
        rd(255, d); chk("f4_rd255", d, 755);

        // Clear from DONE with flags set, then index+1000 frame
        pulse_clear();
        chk("f5_clr_ovf", 32'(overflow), 0);
        chk("f5_clr_lenerr", 32'(len_err), 0);
        chk("f5_clr_done", 32'(frame_done), 0);
        send_range(0, 256, 1000, 255, 1'b0, st, fl);
        chk("f5_lenerr", 32'(len_err), 0);
        chk("f5_len", 32'(frame_len), 256);
        rd(5, d);   chk("f5_rd5", d, 1005);
        rd(255, d); chk("f5_rd255", d, 1255);

        // Reset after 50 beats
        pulse_clear();
        send_range(0, 50, 2000, 255, 1'b0, st, fl);
        rst = 1'b0;
        #1;
        chk("mr_ready", 32'(u_if.ltready), 0);
        chk("mr_rddata", rd_data, 0);
        chk("mr_len", 32'(frame_len), 0);
        chk("mr_done", 32'(frame_done), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mr_ready_after", 32'(u_if.ltready), 1);
        send_range(0, 256, 3000, 255, 1'b0, st, fl);
        chk("mr_len_after", 32'(frame_len), 256);
        chk("mr_lenerr_after", 32'(len_err), 0);
        rd(49, d); chk("mr_rd49", d, 3049);

        // Clear after 50 beats, with a beat offered in the clear cycle
        pulse_clear();
        send_range(0, 50, 4000, 255, 1'b0, st, fl);
        clear = 1'b1;
        u_if.ltvalid = 1'b1;
        u_if.ltdata  = 32'd9999;
        @(negedge clk);
        clear = 1'b0;
        u_if.ltvalid = 1'b0;
        chk("mc_ready", 32'(u_if.ltready), 1);
        chk("mc_len", 32'(frame_len), 0);
        send_range(0, 256, 5000, 255, 1'b0, st, fl);
        chk("mc_len_after", 32'(frame_len), 256);
        chk("mc_lenerr_after", 32'(len_err), 0);
        rd(0, d);  chk("mc_rd0", d, 5000);
        rd(50, d); chk("mc_rd50", d, 5050);

        // ltlast on the first beat
        pulse_clear();
        send_range(0, 1, 7000, 0, 1'b0, st, fl);
        chk("one_done", 32'(frame_done), 1);
        chk("one_len", 32'(frame_len), 1);
        chk("one_lenerr", 32'(len_err), 1);
        rd(0, d); chk("one_rd0", d, 7000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
